// File: rtl/conflict_detector_mlane.sv
// conflict_detector_mlane: multi-lane implication conflict check with a backtrackable trail.
// Define CONFLICT_DETECTOR_STATS_EN to build the saturating conflict counter.
module conflict_detector_mlane #(
    parameter int VAR_W       = 9,
    parameter int LANES       = 2,
    parameter int TRAIL_DEPTH = 512,
    localparam int TRAIL_W    = $clog2(TRAIL_DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [LANES-1:0]         imp_valid,
    input  logic [LANES*VAR_W-1:0]   imp_var,
    input  logic [LANES-1:0]         imp_val,
    input  logic                     undo_req,
    input  logic [TRAIL_W-1:0]       undo_level,
    output logic                     conflict,
    output logic [VAR_W-1:0]         conflict_var,
    output logic [LANES-1:0]         push_en,
    output logic [LANES*VAR_W-1:0]   push_var,
    output logic [LANES-1:0]         push_val,
    output logic [TRAIL_W-1:0]       trail_count,
    output logic                     busy,
    output logic                     overflow,
    output logic [15:0]              conflict_cnt
);
    localparam int NV = 2 ** VAR_W;
    localparam int AW = TRAIL_DEPTH > 1 ? $clog2(TRAIL_DEPTH) : 1;
    localparam logic [TRAIL_W-1:0] FULL = TRAIL_W'(TRAIL_DEPTH);
    localparam logic [TRAIL_W-1:0] ONE  = TRAIL_W'(1);

    typedef enum logic [1:0] {READY, CONFLICT, UNDO} state_e;

    state_e                      state_q, state_d;
    logic [NV-1:0]               asg_q, asg_d, val_q, val_d;
    logic [VAR_W-1:0]            trail_q [TRAIL_DEPTH];
    logic [TRAIL_W-1:0]          count_q, count_d, lvl_q, lvl_d;
    logic                        conflict_q, conflict_d, ovf_q, ovf_d;
    logic [VAR_W-1:0]            cvar_q, cvar_d, pop_var, v;
    logic [LANES-1:0]            pen_q, pen_d, pval_q, pval_d, tw_en;
    logic [LANES*VAR_W-1:0]      pvar_q, pvar_d;
    logic [LANES-1:0][AW-1:0]    tw_addr;
    logic [LANES-1:0][VAR_W-1:0] tw_var;
    logic                        b, conf, red, stop;

    always_comb begin
        state_d    = state_q;
        asg_d      = asg_q;
        val_d      = val_q;
        count_d    = count_q;
        lvl_d      = lvl_q;
        conflict_d = conflict_q;
        cvar_d     = cvar_q;
        ovf_d      = ovf_q;
        pen_d      = '0;
        pvar_d     = '0;
        pval_d     = '0;
        tw_en      = '0;
        tw_addr    = '0;
        tw_var     = '0;
        v          = '0;
        b          = 1'b0;
        conf       = 1'b0;
        red        = 1'b0;
        stop       = 1'b0;
        pop_var    = trail_q[AW'(count_q - ONE)];
        if (state_q == UNDO) begin
            asg_d[pop_var] = 1'b0;
            val_d[pop_var] = 1'b0;
            count_d        = count_q - ONE;
            state_d        = count_d == lvl_q ? READY : UNDO;
        end else if (undo_req) begin
            conflict_d = 1'b0;
            lvl_d      = undo_level;
            state_d    = undo_level < count_q ? UNDO : READY;
        end else if (state_q == READY) begin
            for (int i = 0; i < LANES; i++) begin
                v    = imp_var[i*VAR_W +: VAR_W];
                b    = imp_val[i];
                conf = asg_q[v] && val_q[v] != b;
                red  = asg_q[v] && val_q[v] == b;
                // lower lanes are compared as presented, whether or not they were kept
                for (int j = 0; j < i; j++) begin
                    if (imp_valid[j] && imp_var[j*VAR_W +: VAR_W] == v) begin
                        conf = conf | (imp_val[j] != b);
                        red  = red | (imp_val[j] == b);
                    end
                end
                if (imp_valid[i] && !stop) begin
                    if (conf) begin
                        stop       = 1'b1;
                        conflict_d = 1'b1;
                        cvar_d     = v;
                        state_d    = CONFLICT;
                    end else if (!red) begin
                        if (count_d == FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            asg_d[v]                 = 1'b1;
                            val_d[v]                 = b;
                            tw_en[i]                 = 1'b1;
                            tw_addr[i]               = AW'(count_d);
                            tw_var[i]                = v;
                            count_d                  = count_d + ONE;
                            pen_d[i]                 = 1'b1;
                            pvar_d[i*VAR_W +: VAR_W] = v;
                            pval_d[i]                = b;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= READY;
            asg_q      <= '0;
            val_q      <= '0;
            count_q    <= '0;
            lvl_q      <= '0;
            conflict_q <= 1'b0;
            cvar_q     <= '0;
            ovf_q      <= 1'b0;
            pen_q      <= '0;
            pvar_q     <= '0;
            pval_q     <= '0;
        end else begin
            state_q    <= state_d;
            asg_q      <= asg_d;
            val_q      <= val_d;
            count_q    <= count_d;
            lvl_q      <= lvl_d;
            conflict_q <= conflict_d;
            cvar_q     <= cvar_d;
            ovf_q      <= ovf_d;
            pen_q      <= pen_d;
            pvar_q     <= pvar_d;
            pval_q     <= pval_d;
        end
    end

    // trail storage is never observed past trail_count, so it needs no reset
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (tw_en[i]) trail_q[tw_addr[i]] <= tw_var[i];
        end
    end

`ifdef CONFLICT_DETECTOR_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else if (state_q == READY && state_d == CONFLICT && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = 16'd0;
`endif

    assign conflict     = conflict_q;
    assign conflict_var = cvar_q;
    assign push_en      = pen_q;
    assign push_var     = pvar_q;
    assign push_val     = pval_q;
    assign trail_count  = count_q;
    assign busy         = state_q == UNDO;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_conflict_detector_mlane.sv
// tb_conflict_detector_mlane: scoreboard bench for the two-lane detector (512-deep and 4-deep trails).
module tb_conflict_detector_mlane;
    typedef struct {
        string       n;
        logic [1:0]  vld;
        logic [8:0]  v0, v1;
        logic [1:0]  val;
        logic        undo;
        logic [9:0]  lvl;
        logic [43:0] exp;
    } stim_t;

    logic        clock = 1'b0, reset = 1'b0;
    logic [1:0]  imp_valid = '0, imp_val = '0, push_en, push_val;
    logic [17:0] imp_var = '0, push_var;
    logic        undo_req = 1'b0, conflict, busy, overflow;
    logic [9:0]  undo_level = '0, trail_count;
    logic [8:0]  conflict_var;
    logic [15:0] conflict_cnt;

    logic [1:0]  d4_valid = '0, d4_val = '0, d4_push_en, d4_push_val;
    logic [17:0] d4_var = '0, d4_push_var;
    logic        d4_undo = 1'b0, d4_conflict, d4_busy, d4_overflow;
    logic [2:0]  d4_lvl = '0, d4_count;
    logic [8:0]  d4_cvar;
    logic [15:0] d4_cnt;

    int    checks = 0, errors = 0;
    stim_t sb[$];

`ifdef CONFLICT_DETECTOR_STATS_EN
    localparam logic [15:0] EXP_CNT = 16'd3;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
`endif

    conflict_detector_mlane dut (
        .clock(clock), .reset(reset), .imp_valid(imp_valid), .imp_var(imp_var), .imp_val(imp_val),
        .undo_req(undo_req), .undo_level(undo_level), .conflict(conflict), .conflict_var(conflict_var),
        .push_en(push_en), .push_var(push_var), .push_val(push_val), .trail_count(trail_count),
        .busy(busy), .overflow(overflow), .conflict_cnt(conflict_cnt)
    );

    conflict_detector_mlane #(.TRAIL_DEPTH(4)) dut4 (
        .clock(clock), .reset(reset), .imp_valid(d4_valid), .imp_var(d4_var), .imp_val(d4_val),
        .undo_req(d4_undo), .undo_level(d4_lvl), .conflict(d4_conflict), .conflict_var(d4_cvar),
        .push_en(d4_push_en), .push_var(d4_push_var), .push_val(d4_push_val), .trail_count(d4_count),
        .busy(d4_busy), .overflow(d4_overflow), .conflict_cnt(d4_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // push_var/push_val only matter on pushing lanes, conflict_var only while conflict is set
    function automatic logic [43:0] mk(input logic [1:0] pe, input logic [8:0] v0, input logic [8:0] v1,
                                       input logic [1:0] pl, input logic c, input logic [8:0] cv,
                                       input logic [9:0] tc, input logic bz, input logic o);
        return {pe, pe[1] ? v1 : 9'd0, pe[0] ? v0 : 9'd0, pl & pe, c, c ? cv : 9'd0, tc, bz, o};
    endfunction

    function automatic logic [43:0] obs();
        return {push_en, push_en[1] ? push_var[17:9] : 9'd0, push_en[0] ? push_var[8:0] : 9'd0,
                push_val & push_en, conflict, conflict ? conflict_var : 9'd0, trail_count, busy, overflow};
    endfunction

    function automatic logic [43:0] mk4(input logic [1:0] pe, input logic o, input logic [2:0] tc);
        return {38'd0, pe, o, tc};
    endfunction

    function automatic logic [43:0] obs4();
        return {38'd0, d4_push_en, d4_overflow, d4_count};
    endfunction

    function automatic stim_t st(input string n, input logic [1:0] vld, input logic [8:0] v0, input logic b0,
                                 input logic [8:0] v1, input logic b1, input logic u, input logic [9:0] l,
                                 input logic [43:0] e);
        st.n = n; st.vld = vld; st.v0 = v0; st.v1 = v1; st.val = {b1, b0};
        st.undo = u; st.lvl = l; st.exp = e;
    endfunction

    task automatic drive(input stim_t s, input bit four);
        if (four) begin
            d4_valid = s.vld; d4_var = {s.v1, s.v0}; d4_val = s.val; d4_undo = s.undo; d4_lvl = s.lvl[2:0];
        end else begin
            imp_valid = s.vld; imp_var = {s.v1, s.v0}; imp_val = s.val; undo_req = s.undo; undo_level = s.lvl;
        end
    endtask

    task automatic idle();
        imp_valid = '0; imp_val = '0; imp_var = '0; undo_req = 1'b0; undo_level = '0;
        d4_valid = '0; d4_val = '0; d4_var = '0; d4_undo = 1'b0; d4_lvl = '0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs() !== 44'd0 || conflict_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_main: got %h/%h expected 0/0", obs(), conflict_cnt);
        end
        checks++;
        if (obs4() !== 44'd0) begin
            errors++; $display("FAIL reset_dut4: got %h expected 0", obs4());
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_lanes();
        stim_t s[$], e;
        s.push_back(st("lanes_both", 2'b11, 1, 0, 2, 1, 0, 0, mk(2'b11, 1, 2, 2'b10, 0, 0, 2, 0, 0)));
        s.push_back(st("lanes_conf", 2'b01, 1, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 1, 2, 0, 0)));
        s.push_back(st("conf_sticky", 2'b00, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 1, 2, 0, 0)));
        s.push_back(st("conf_ignores_imp", 2'b01, 5, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 1, 2, 0, 0)));
        s.push_back(st("undo_no_pop", 2'b00, 0, 0, 0, 0, 1, 2, mk(0, 0, 0, 0, 0, 0, 2, 0, 0)));
        s.push_back(st("ready_again", 2'b01, 5, 1, 0, 0, 0, 0, mk(2'b01, 5, 0, 2'b01, 0, 0, 3, 0, 0)));
        foreach (s[i]) begin
            drive(s[i], 0); sb.push_back(s[i]);
            @(posedge clock); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs(), e.exp); end
        end
        idle();
    endtask

    task automatic test_same_cycle();
        stim_t s[$], e;
        s.push_back(st("intra_conf", 2'b11, 3, 1, 3, 0, 0, 0, mk(2'b01, 3, 0, 2'b01, 1, 3, 4, 0, 0)));
        s.push_back(st("undo_at_count", 2'b00, 0, 0, 0, 0, 1, 4, mk(0, 0, 0, 0, 0, 0, 4, 0, 0)));
        s.push_back(st("intra_same", 2'b11, 4, 1, 4, 1, 0, 0, mk(2'b01, 4, 0, 2'b01, 0, 0, 5, 0, 0)));
        s.push_back(st("undo_all", 2'b00, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 5, 1, 0)));
        for (int k = 4; k >= 0; k--)
            s.push_back(st("pop_all", 2'b00, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 10'(k), k != 0, 0)));
        foreach (s[i]) begin
            drive(s[i], 0); sb.push_back(s[i]);
            @(posedge clock); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs(), e.exp); end
        end
        idle();
    endtask

    task automatic test_undo();
        stim_t s[$], e;
        s.push_back(st("fill_a", 2'b11, 10, 0, 11, 0, 0, 0, mk(2'b11, 10, 11, 0, 0, 0, 2, 0, 0)));
        s.push_back(st("fill_b", 2'b11, 12, 0, 13, 0, 0, 0, mk(2'b11, 12, 13, 0, 0, 0, 4, 0, 0)));
        s.push_back(st("fill_c", 2'b01, 14, 0, 0, 0, 0, 0, mk(2'b01, 14, 0, 0, 0, 0, 5, 0, 0)));
        s.push_back(st("conf_10", 2'b01, 10, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 10, 5, 0, 0)));
        s.push_back(st("undo_to_2", 2'b00, 0, 0, 0, 0, 1, 2, mk(0, 0, 0, 0, 0, 0, 5, 1, 0)));
        s.push_back(st("pop_ign_inputs", 2'b01, 20, 1, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 4, 1, 0)));
        s.push_back(st("pop_3", 2'b00, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 3, 1, 0)));
        s.push_back(st("pop_last", 2'b00, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 2, 0, 0)));
        s.push_back(st("reimply_13_14", 2'b11, 13, 1, 14, 1, 0, 0, mk(2'b11, 13, 14, 2'b11, 0, 0, 4, 0, 0)));
        s.push_back(st("reimply_12", 2'b01, 12, 1, 0, 0, 0, 0, mk(2'b01, 12, 0, 2'b01, 0, 0, 5, 0, 0)));
        s.push_back(st("kept_10_redundant", 2'b01, 10, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5, 0, 0)));
        s.push_back(st("undo_all", 2'b00, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 5, 1, 0)));
        for (int k = 4; k >= 0; k--)
            s.push_back(st("pop_all", 2'b00, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 10'(k), k != 0, 0)));
        foreach (s[i]) begin
            drive(s[i], 0); sb.push_back(s[i]);
            @(posedge clock); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs(), e.exp); end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        stim_t s[$], e;
        s.push_back(st("b2b_first", 2'b01, 30, 1, 0, 0, 0, 0, mk(2'b01, 30, 0, 2'b01, 0, 0, 1, 0, 0)));
        s.push_back(st("b2b_redundant", 2'b01, 30, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0)));
        s.push_back(st("b2b_conf", 2'b01, 30, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 30, 1, 0, 0)));
        s.push_back(st("b2b_undo", 2'b00, 0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0)));
        s.push_back(st("undo_wins", 2'b01, 31, 1, 0, 0, 1, 10, mk(0, 0, 0, 0, 0, 0, 1, 0, 0)));
        s.push_back(st("dropped_not_written", 2'b01, 31, 0, 0, 0, 0, 0, mk(2'b01, 31, 0, 0, 0, 0, 2, 0, 0)));
        s.push_back(st("lane1_only", 2'b10, 0, 0, 32, 1, 0, 0, mk(2'b10, 0, 32, 2'b10, 0, 0, 3, 0, 0)));
        s.push_back(st("undo_all", 2'b00, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 3, 1, 0)));
        for (int k = 2; k >= 0; k--)
            s.push_back(st("pop_all", 2'b00, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 10'(k), k != 0, 0)));
        foreach (s[i]) begin
            drive(s[i], 0); sb.push_back(s[i]);
            @(posedge clock); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs(), e.exp); end
        end
        idle();
    endtask

    task automatic test_overflow();
        stim_t s[$], e;
        s.push_back(st("ovf_fill2", 2'b11, 1, 1, 2, 1, 0, 0, mk4(2'b11, 0, 2)));
        s.push_back(st("ovf_fill3", 2'b01, 3, 1, 0, 0, 0, 0, mk4(2'b01, 0, 3)));
        s.push_back(st("ovf_lane1_drop", 2'b11, 4, 1, 5, 1, 0, 0, mk4(2'b01, 1, 4)));
        s.push_back(st("ovf_full", 2'b11, 6, 1, 1, 1, 0, 0, mk4(2'b00, 1, 4)));
        s.push_back(st("ovf_undo", 2'b00, 0, 0, 0, 0, 1, 3, mk4(2'b00, 1, 4)));
        s.push_back(st("ovf_pop", 2'b00, 0, 0, 0, 0, 0, 0, mk4(2'b00, 1, 3)));
        s.push_back(st("ovf_room_again", 2'b01, 7, 1, 0, 0, 0, 0, mk4(2'b01, 1, 4)));
        foreach (s[i]) begin
            drive(s[i], 1); sb.push_back(s[i]);
            @(posedge clock); #1;
            e = sb.pop_front(); checks++;
            if (obs4() !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs4(), e.exp); end
        end
        idle();
    endtask

    task automatic test_reset_mid_undo();
        stim_t s[$], e;
        s.push_back(st("pre_fill", 2'b11, 1, 0, 2, 0, 0, 0, mk(2'b11, 1, 2, 0, 0, 0, 2, 0, 0)));
        s.push_back(st("pre_undo", 2'b00, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0)));
        foreach (s[i]) begin
            drive(s[i], 0); sb.push_back(s[i]);
            @(posedge clock); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs(), e.exp); end
        end
        idle();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs() !== 44'd0 || conflict_cnt !== 16'd0) begin
            errors++; $display("FAIL async_reset: got %h/%h expected 0/0", obs(), conflict_cnt);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        drive(st("post_reset", 2'b01, 1, 1, 0, 0, 0, 0, mk(2'b01, 1, 0, 2'b01, 0, 0, 1, 0, 0)), 0);
        sb.push_back(st("post_reset", 2'b01, 1, 1, 0, 0, 0, 0, mk(2'b01, 1, 0, 2'b01, 0, 0, 1, 0, 0)));
        @(posedge clock); #1;
        e = sb.pop_front(); checks++;
        if (obs() !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs(), e.exp); end
        idle();
    endtask

    task automatic test_stats();
        stim_t s[$], e;
        for (int k = 0; k < 3; k++) begin
            s.push_back(st("stats_conf", 2'b01, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 1, 1, 0, 0)));
            s.push_back(st("stats_undo", 2'b00, 0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0)));
        end
        foreach (s[i]) begin
            drive(s[i], 0); sb.push_back(s[i]);
            @(posedge clock); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs(), e.exp); end
        end
        idle();
        checks++;
        if (conflict_cnt !== EXP_CNT) begin
            errors++; $display("FAIL conflict_cnt: got %0d expected %0d", conflict_cnt, EXP_CNT);
        end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_same_cycle();
        test_undo();
        test_back_to_back();
        test_overflow();
        test_reset_mid_undo();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
